// File: rtl/mem_param_ctrl.sv
// Parameterised word memory with byte-enable writes, pipelined reads of
// configurable latency, range checking and a one-word-per-cycle zero-fill sweep.
//
// state | meaning
// IDLE  | accepts one read/write per cycle, or starts a clear sweep
// CLEAR | zeroes word clr_idx each cycle, busy=1, requests ignored
module mem_param_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic                  clear,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic                  err,
  output logic                  busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CLR_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CLR_W-1:0] LAST_IDX = CLR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [CLR_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, in_range, rd_accept, wr_accept;
  logic [DATA_W-1:0] rd_word;

  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] err_pipe;
  logic [DATA_W-1:0] data_pipe [RD_LAT];

  // rst gates acceptance so nothing touches the array while reset is held
  assign accept    = (state == IDLE) && en && !clear && !rst;
  assign in_range  = {1'b0, address} < DEPTH_A;
  assign rd_accept = accept && !wr_en;
  assign wr_accept = accept && wr_en && in_range;
  assign rd_word   = in_range ? mem[address[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (clear) state_nxt = CLEAR;
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      clr_idx <= '0;
    else if (state == CLEAR && clr_idx != LAST_IDX) clr_idx <= clr_idx + CLR_W'(1);
    else                                          clr_idx <= '0;
  end

  // Array has no reset: contents survive rst, and an aborted sweep leaves the tail intact
  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) begin
      mem[clr_idx[IDX_W-1:0]] <= '0;
    end else if (wr_accept) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byte_en[b]) mem[address[IDX_W-1:0]][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  // Each stage only moves data with a valid token, so data_out holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) data_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_accept;
      err_pipe[0] <= rd_accept && !in_range;
      if (rd_accept) data_pipe[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign data_out  = data_pipe[RD_LAT-1];
  assign valid_out = vld_pipe[RD_LAT-1];
  assign err       = err_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_param_ctrl.sv
// Bench for mem_param_ctrl: three instances (defaults, RD_LAT=3, DEPTH=12) share
// stimulus and are each compared every cycle against a calendar-based memory model.
module tb_mem_param_ctrl;

  logic        clk = 0, rst = 0, en = 0, wr_en = 0, clear = 0;
  logic [3:0]  address = 0, byte_en = 0;
  logic [31:0] data_in = 0;
  logic [31:0] dout [3];
  logic [2:0]  vout, eout, bout;

  always #5 clk = ~clk;

  mem_param_ctrl u_def (.clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .address(address),
    .data_in(data_in), .byte_en(byte_en), .clear(clear), .data_out(dout[0]),
    .valid_out(vout[0]), .err(eout[0]), .busy(bout[0]));
  mem_param_ctrl #(.RD_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .en(en), .wr_en(wr_en),
    .address(address), .data_in(data_in), .byte_en(byte_en), .clear(clear),
    .data_out(dout[1]), .valid_out(vout[1]), .err(eout[1]), .busy(bout[1]));
  mem_param_ctrl #(.DEPTH(12), .ADDR_W(4)) u_d12 (.clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .address(address), .data_in(data_in), .byte_en(byte_en), .clear(clear),
    .data_out(dout[2]), .valid_out(vout[2]), .err(eout[2]), .busy(bout[2]));

  function automatic int lat_of(int i);   return (i == 1) ? 3 : 1;   endfunction
  function automatic int depth_of(int i); return (i == 2) ? 12 : 16; endfunction

  // reference model: word array, sweep progress, and a calendar of read results by due edge
  logic [31:0] m_mem [3][16];
  bit          m_busy [3];
  int          m_cidx [3];
  bit          s_v [3][8];
  bit          s_e [3][8];
  logic [31:0] s_d [3][8];
  bit          x_v [3], x_e [3];
  logic [31:0] x_d [3];
  int          ecnt = 0;
  int          n_pass = 0, n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(int i);
    int d = depth_of(i);
    int slot;
    if (m_busy[i]) begin
      m_mem[i][m_cidx[i]] = '0;
      m_cidx[i]++;
      if (m_cidx[i] == d) m_busy[i] = 0;
    end else if (clear) begin
      m_busy[i] = 1;
      m_cidx[i] = 0;
    end else if (en) begin
      if (wr_en) begin
        if (int'(address) < d)
          for (int b = 0; b < 4; b++)
            if (byte_en[b]) m_mem[i][address][8*b +: 8] = data_in[8*b +: 8];
      end else begin
        slot = (ecnt + lat_of(i) - 1) % 8;
        s_v[i][slot] = 1;
        s_e[i][slot] = int'(address) >= d;
        s_d[i][slot] = (int'(address) < d) ? m_mem[i][address] : 32'h0;
      end
    end
  endtask

  task automatic model_post(int i);
    int slot = ecnt % 8;
    x_v[i] = s_v[i][slot];
    x_e[i] = s_v[i][slot] && s_e[i][slot];
    if (s_v[i][slot]) x_d[i] = s_d[i][slot];
    s_v[i][slot] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_cidx[i] = 0;
      x_v[i] = 0; x_e[i] = 0; x_d[i] = '0;
      for (int s = 0; s < 8; s++) s_v[i][s] = 0;
    end
  endtask

  task automatic check_inst(int i);
    chk($sformatf("valid%0d", i), vout[i], x_v[i]);
    chk($sformatf("err%0d", i),   eout[i], x_e[i]);
    chk($sformatf("busy%0d", i),  bout[i], m_busy[i]);
    chk($sformatf("data%0d", i),  dout[i], x_d[i]);
  endtask

  task automatic tick();
    if (!rst) for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk); #1;
    if (!rst) for (int i = 0; i < 3; i++) model_post(i);
    ecnt++;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // asynchronous: outputs are checked before any clock edge sees rst
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check_inst(i);
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_op(bit e, bit w, logic [3:0] a, logic [31:0] d, logic [3:0] be);
    en = e; wr_en = w; address = a; data_in = d; byte_en = be;
  endtask

  typedef struct {
    bit          en, wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          v;
    logic [31:0] xd;
    bit          xe;
  } vec_t;

  function automatic vec_t mk(bit e, bit w, logic [3:0] a, logic [31:0] d, logic [3:0] be,
                              bit v, logic [31:0] xd, bit xe);
    vec_t r;
    r.en = e; r.wr = w; r.a = a; r.d = d; r.be = be; r.v = v; r.xd = xd; r.xe = xe;
    return r;
  endfunction

  vec_t tbl [12];
  int   cnt0, cnt2;

  initial begin
    tbl[0]  = mk(1, 1, 3,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0);
    tbl[1]  = mk(1, 0, 3,  32'h0,        4'h0, 1, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 1, 5,  32'h11223344, 4'hF, 0, 32'hDEADBEEF, 0);
    tbl[3]  = mk(1, 1, 5,  32'hAABBCCDD, 4'h5, 0, 32'hDEADBEEF, 0);
    tbl[4]  = mk(1, 0, 5,  32'h0,        4'h0, 1, 32'h11BB33DD, 0);
    tbl[5]  = mk(1, 1, 5,  32'hFFFFFFFF, 4'h0, 0, 32'h11BB33DD, 0);
    tbl[6]  = mk(1, 0, 5,  32'h0,        4'h0, 1, 32'h11BB33DD, 0);
    tbl[7]  = mk(1, 0, 3,  32'h0,        4'h0, 1, 32'hDEADBEEF, 0);
    tbl[8]  = mk(1, 1, 3,  32'h01020304, 4'hF, 0, 32'hDEADBEEF, 0);
    tbl[9]  = mk(1, 0, 3,  32'h0,        4'h0, 1, 32'h01020304, 0);
    tbl[10] = mk(1, 0, 15, 32'h0,        4'h0, 1, 32'h0,        0);
    tbl[11] = mk(0, 0, 0,  32'h0,        4'h0, 0, 32'h0,        0);

    #2;
    do_reset();

    // zero-fill so every model word is defined
    clear = 1; tick(); clear = 0;
    repeat (16) tick();

    for (int k = 0; k < 12; k++) begin
      set_op(tbl[k].en, tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].be);
      tick();
      chk($sformatf("tbl%0d_valid", k), vout[0], tbl[k].v);
      chk($sformatf("tbl%0d_data", k),  dout[0], tbl[k].xd);
      chk($sformatf("tbl%0d_err", k),   eout[0], tbl[k].xe);
    end

    // out-of-range on DEPTH=12
    set_op(1, 1, 13, 32'h12345678, 4'hF); tick();
    set_op(1, 0, 13, 0, 0); tick();
    chk("oor_valid", vout[2], 1); chk("oor_err", eout[2], 1); chk("oor_data", dout[2], 0);
    chk("d16_13", dout[0], 32'h12345678);
    set_op(1, 0, 3, 0, 0); tick();
    chk("d12_3", dout[2], 32'h01020304);

    // RD_LAT=3 back-to-back reads
    for (int a = 0; a < 3; a++) begin set_op(1, 1, a[3:0], 32'hC0 + a, 4'hF); tick(); end
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) set_op(1, 0, 4'(k - 1), 0, 0); else set_op(0, 0, 0, 0, 0);
      tick();
      chk($sformatf("lat3_v%0d", k), vout[1], (k >= 3 && k <= 5));
      if (k >= 3 && k <= 5) chk($sformatf("lat3_d%0d", k), dout[1], 32'hC0 + k - 3);
    end

    // clear with en in the same cycle
    set_op(1, 0, 3, 0, 0); clear = 1; tick(); clear = 0;
    chk("clr_drop", vout[0], 0);
    cnt0 = bout[0]; cnt2 = bout[2];
    set_op(1, 1, 0, 32'hFFFFFFFF, 4'hF);
    for (int k = 0; k < 19; k++) begin
      if (k == 15) set_op(0, 0, 0, 0, 0);
      tick();
      cnt0 += bout[0]; cnt2 += bout[2];
    end
    chk("busy_len16", cnt0, 16);
    chk("busy_len12", cnt2, 12);
    for (int a = 0; a < 16; a++) begin
      set_op(1, 0, a[3:0], 0, 0); tick();
      chk($sformatf("clr_rd%0d", a), dout[0], 0);
      chk($sformatf("clr_v%0d", a), vout[0], 1);
    end

    // reset mid-sweep at index 5
    for (int a = 0; a < 16; a++) begin set_op(1, 1, a[3:0], 32'hA0 + a, 4'hF); tick(); end
    set_op(0, 0, 0, 0, 0); clear = 1; tick(); clear = 0;
    repeat (5) tick();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      set_op(1, 0, a[3:0], 0, 0); tick();
      chk($sformatf("abort_rd%0d", a), dout[0], (a < 5) ? 32'h0 : 32'hA0 + a);
    end

    // randomized traffic with occasional clears and resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        set_op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        clear = ($urandom_range(0, 29) == 0);
        tick();
      end
    end
    set_op(0, 0, 0, 0, 0); clear = 0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
